// File: rtl/bank_pkg.sv
// Shared definitions for the bank queuing blocks.
//   popcount  : population count over a zero-extended mask (up to MaxTellers bits)
//   id_width  : index width for n windows, at least 1 bit
//   NTellersDefault : default window count shared with the queue and display blocks
package bank_pkg;

  localparam int unsigned NTellersDefault = 3;
  localparam int unsigned MaxTellers      = 64;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned popcount(input logic [MaxTellers-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MaxTellers; i++) begin
      cnt += {31'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/teller_pool_tracker_if.sv
// Bundle between the customer queue / teller windows (master) and the tracker (slave).
//   master drives : teller_on, cust_valid, done
//   slave drives  : cust_ready, assign_id, busy, open_count, free_count, busy_count,
//                   served_total
interface teller_pool_tracker_if #(
  parameter int unsigned N_TELLERS = bank_pkg::NTellersDefault,
  parameter int unsigned TOTAL_W   = 16
);
  localparam int unsigned CNT_W = $clog2(N_TELLERS + 1);
  localparam int unsigned ID_W  = bank_pkg::id_width(N_TELLERS);

  logic [N_TELLERS-1:0] teller_on;
  logic                 cust_valid;
  logic                 cust_ready;
  logic [ID_W-1:0]      assign_id;
  logic [N_TELLERS-1:0] done;
  logic [N_TELLERS-1:0] busy;
  logic [CNT_W-1:0]     open_count;
  logic [CNT_W-1:0]     free_count;
  logic [CNT_W-1:0]     busy_count;
  logic [TOTAL_W-1:0]   served_total;

  modport master (
    output teller_on, cust_valid, done,
    input  cust_ready, assign_id, busy, open_count, free_count, busy_count, served_total
  );

  modport slave (
    input  teller_on, cust_valid, done,
    output cust_ready, assign_id, busy, open_count, free_count, busy_count, served_total
  );

endinterface

// File: rtl/teller_rr_arbiter.sv
// Combinational round-robin first-set search.
//   req         : request mask, one bit per window
//   start       : index where the upward search begins (must be < N)
//   grant_valid : some request bit is set
//   grant_id    : first set bit at or above start, wrapping N-1 -> 0; equals start when
//                 nothing is requested
module teller_rr_arbiter #(
  parameter int unsigned N    = 3,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] start,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id
);

  always_comb begin
    int unsigned idx;
    grant_valid = 1'b0;
    grant_id    = start;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(start) + i;
      if (idx >= N) idx = idx - N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/teller_pool_tracker.sv
// Tracks N_TELLERS teller windows: registers the open mask, keeps per-window busy state,
// grants the queue head to a free open window round-robin and publishes counts.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of teller_pool_tracker_if (handshake, done pulses, status)
module teller_pool_tracker
  import bank_pkg::*;
#(
  parameter int unsigned N_TELLERS = NTellersDefault,
  parameter int unsigned TOTAL_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  teller_pool_tracker_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(N_TELLERS + 1);
  localparam int unsigned ID_W  = id_width(N_TELLERS);

  logic [N_TELLERS-1:0] on_q;
  logic [N_TELLERS-1:0] busy_q, busy_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [TOTAL_W-1:0]   served_q;
  logic [N_TELLERS-1:0] free;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;
  logic                 accept;

  assign free = on_q & ~busy_q;

  teller_rr_arbiter #(
    .N    (N_TELLERS),
    .ID_W (ID_W)
  ) u_arb (
    .req         (free),
    .start       (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign accept = bus.cust_valid & grant_valid;

  // Granted window is always free, so it never collides with a done on the same bit.
  always_comb begin
    busy_d   = busy_q & ~bus.done;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      busy_d[grant_id] = 1'b1;
      rr_ptr_d = (32'(grant_id) == N_TELLERS - 1) ? '0 : grant_id + ID_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      on_q     <= '0;
      busy_q   <= '0;
      rr_ptr_q <= '0;
      served_q <= '0;
    end else begin
      on_q     <= bus.teller_on;
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
      if (accept && (served_q != {TOTAL_W{1'b1}})) begin
        served_q <= served_q + TOTAL_W'(1);
      end
    end
  end

  // Zero-extend masks to the package popcount width.
  logic [MaxTellers-1:0] on_ext, free_ext, busy_ext;

  always_comb begin
    on_ext   = '0;
    free_ext = '0;
    busy_ext = '0;
    on_ext[N_TELLERS-1:0]   = on_q;
    free_ext[N_TELLERS-1:0] = free;
    busy_ext[N_TELLERS-1:0] = busy_q;
  end

  assign bus.cust_ready   = grant_valid;
  assign bus.assign_id    = grant_id;
  assign bus.busy         = busy_q;
  assign bus.open_count   = CNT_W'(popcount(on_ext));
  assign bus.free_count   = CNT_W'(popcount(free_ext));
  assign bus.busy_count   = CNT_W'(popcount(busy_ext));
  assign bus.served_total = served_q;

endmodule

// File: tb/tb_teller_pool_tracker.sv
module tb_teller_pool_tracker;

  logic clk;
  logic rst;

  int unsigned checks;
  int unsigned errors;
  int unsigned sb_q[$];

  teller_pool_tracker_if #(.N_TELLERS(3), .TOTAL_W(16)) a_if ();
  teller_pool_tracker_if #(.N_TELLERS(3), .TOTAL_W(2))  b_if ();

  // Saturation instance sees the same stimulus.
  assign b_if.teller_on  = a_if.teller_on;
  assign b_if.cust_valid = a_if.cust_valid;
  assign b_if.done       = a_if.done;

  teller_pool_tracker #(.N_TELLERS(3), .TOTAL_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  teller_pool_tracker #(.N_TELLERS(3), .TOTAL_W(2)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each accept seen by the DUT pops the expected window index.
  always @(negedge clk) begin
    if (!rst && a_if.cust_valid && a_if.cust_ready) begin
      chk("accept_expected", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) chk("assign_id", 32'(a_if.assign_id), sb_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic status(input string tag, input int unsigned busy, input int unsigned open,
                        input int unsigned free, input int unsigned bcnt, input int unsigned rdy);
    chk({tag, "_busy"}, 32'(a_if.busy), busy);
    chk({tag, "_open"}, 32'(a_if.open_count), open);
    chk({tag, "_free"}, 32'(a_if.free_count), free);
    chk({tag, "_busy_count"}, 32'(a_if.busy_count), bcnt);
    chk({tag, "_ready"}, 32'(a_if.cust_ready), rdy);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a_if.teller_on  = '0;
    a_if.cust_valid = 1'b0;
    a_if.done       = '0;
    tick();
    tick();
    status("reset", 0, 0, 0, 0, 0);
    chk("reset_assign_id", 32'(a_if.assign_id), 0);
    chk("reset_served", 32'(a_if.served_total), 0);
    rst = 1'b0;
    tick();

    // Open all windows; visible one cycle later.
    a_if.teller_on = 3'b111;
    #1;
    chk("open_not_yet", 32'(a_if.open_count), 0);
    tick();
    status("opened", 0, 3, 3, 0, 1);
    chk("opened_assign_id", 32'(a_if.assign_id), 0);

    // Three back-to-back accepts.
    a_if.cust_valid = 1'b1;
    sb_q.push_back(0);
    sb_q.push_back(1);
    sb_q.push_back(2);
    tick();
    status("acc1", 3'b001, 3, 2, 1, 1);
    tick();
    status("acc2", 3'b011, 3, 1, 2, 1);
    tick();
    status("acc3", 3'b111, 3, 0, 3, 0);
    chk("acc3_served", 32'(a_if.served_total), 3);
    tick();
    chk("held_no_accept_served", 32'(a_if.served_total), 3);
    a_if.cust_valid = 1'b0;

    // Done on window 1, then window 0; pointer has wrapped to 0.
    a_if.done = 3'b010;
    tick();
    status("done1", 3'b101, 3, 1, 2, 1);
    chk("done1_assign_id", 32'(a_if.assign_id), 1);
    a_if.done = 3'b001;
    tick();
    status("done0", 3'b100, 3, 2, 1, 1);
    chk("done0_assign_id", 32'(a_if.assign_id), 0);
    a_if.done = '0;
    a_if.cust_valid = 1'b1;
    sb_q.push_back(0);
    tick();
    chk("rr_after0_assign_id", 32'(a_if.assign_id), 1);
    sb_q.push_back(1);
    tick();
    a_if.cust_valid = 1'b0;
    status("refill", 3'b111, 3, 0, 3, 0);
    chk("served5", 32'(a_if.served_total), 5);
    chk("sat_served", 32'(b_if.served_total), 3);

    // Done on idle window is ignored.
    a_if.done = 3'b010;
    tick();
    a_if.done = 3'b010;
    tick();
    a_if.done = '0;
    chk("idle_done_busy", 32'(a_if.busy), 3'b101);
    chk("rr2_assign_id", 32'(a_if.assign_id), 1);
    a_if.cust_valid = 1'b1;
    sb_q.push_back(1);
    tick();
    a_if.cust_valid = 1'b0;
    chk("served6", 32'(a_if.served_total), 6);
    chk("sat_served_hold", 32'(b_if.served_total), 3);

    // Close window 2 while busy.
    a_if.teller_on = 3'b011;
    tick();
    status("closed", 3'b111, 2, 0, 3, 0);
    a_if.done = 3'b100;
    tick();
    status("closed_done2", 3'b011, 2, 0, 2, 0);
    a_if.done = 3'b001;
    tick();
    a_if.done = '0;
    status("closed_done0", 3'b010, 2, 1, 1, 1);
    chk("closed_assign_id", 32'(a_if.assign_id), 0);
    a_if.cust_valid = 1'b1;
    sb_q.push_back(0);
    tick();
    a_if.cust_valid = 1'b0;
    status("closed_full", 3'b011, 2, 0, 2, 0);
    chk("served7", 32'(a_if.served_total), 7);

    // Reopen, fill, then asynchronous reset mid-cycle.
    a_if.teller_on = 3'b111;
    tick();
    chk("reopen_assign_id", 32'(a_if.assign_id), 2);
    a_if.cust_valid = 1'b1;
    sb_q.push_back(2);
    tick();
    a_if.cust_valid = 1'b0;
    chk("prereset_busy", 32'(a_if.busy), 3'b111);
    #2;
    rst = 1'b1;
    #1;
    status("midreset", 0, 0, 0, 0, 0);
    chk("midreset_served", 32'(a_if.served_total), 0);
    chk("midreset_assign_id", 32'(a_if.assign_id), 0);
    chk("midreset_sat_served", 32'(b_if.served_total), 0);
    tick();
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/teller_pool_tracker.md
# teller_pool_tracker

Parametrised teller-window tracker for the bank queuing system. It generalises the fixed 3-window teller count to `N_TELLERS` windows and keeps per-teller busy state. It assigns the customer at the head of the queue to a free, open window using round-robin, and publishes open, free and busy counts to the display and queue controller. It sits between the customer queue (upstream) and the teller windows (downstream).

## Interface
- `N_TELLERS`, default 3: number of teller windows; must be ≥1.
- `TOTAL_W`, default 16: width of the served-customer counter.
- `CNT_W`, derived: `$clog2(N_TELLERS+1)`. Not for override.
- `ID_W`, derived: `max(1, $clog2(N_TELLERS))`. Not for override.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `teller_on`  in  N_TELLERS  window staffed/open mask, level.
- `cust_valid`  in  1  a customer is waiting at the queue head.
- `cust_ready`  out  1  a free open window exists; combinational from registered state.
- `assign_id`  out  ID_W  window index granted; meaningful when `cust_ready`=1.
- `done`  in  N_TELLERS  per-window service-complete pulse.
- `busy`  out  N_TELLERS  registered busy mask.
- `open_count`  out  CNT_W  popcount of the registered `teller_on`.
- `free_count`  out  CNT_W  popcount of (registered `teller_on` & ~`busy`).
- `busy_count`  out  CNT_W  popcount of `busy`.
- `served_total`  out  TOTAL_W  customers accepted; saturates at all-ones.

## Operation
- **Registered state:** `on_q` (`teller_on` register), `busy`, `rr_ptr` (ID_W bits), `served_total`.
- **Free mask:** `free = on_q & ~busy`.
- **Ready and grant:**
  - `cust_ready = |free`.
  - `assign_id` is the first set bit of `free`, searched upward from `rr_ptr` with wrap from N_TELLERS-1 to 0.
  - When `cust_ready`=0, `assign_id` = `rr_ptr`, which is don't-care.
- **Accept** occurs when `cust_valid && cust_ready` at an edge. On accept:
  - `busy[assign_id]` is set.
  - `rr_ptr` becomes `assign_id`+1, wrapping to 0 after N_TELLERS-1.
  - `served_total` increments, saturating.
- **Done:** `done[i]` clears `busy[i]`. A `done` on a non-busy window is ignored.
- **Done and accept in the same cycle:** never on the same window, because only free windows are granted. Both updates apply.
- **Closing a busy window:** `on_q[i]` falls while `busy[i]`=1. The busy bit is retained until `done[i]`. The window is not granted while closed.
  - `busy_count` may therefore exceed `open_count`.
- **Arithmetic:** all counts are exact popcounts and cannot overflow, since CNT_W covers 0..N_TELLERS.

## Timing
- **Reset values:** `on_q`=0, `busy`=0, `rr_ptr`=0, `served_total`=0.
  - This gives `cust_ready`=0, `assign_id`=0 and all counts 0.
- **Reset mid-operation:** asynchronous assertion clears all state immediately. All pending assignments are dropped.
- **`teller_on`:** a change is visible in `open_count`, `free_count` and `cust_ready` one cycle after it is sampled.
- **Accept:** the window shows `busy`=1 in the cycle after the accepting edge. `free_count` drops by 1 in that same cycle.
- **`done`:**
  - A `done` pulse sampled at edge k makes that window grantable from cycle k+1.
  - Minimum window turnaround is 2 cycles (accept, then done).
- **Throughput:** one accept per cycle maximum. The `cust_valid`/`cust_ready` handshake needs no stall state.

## Structure
- **Shared package `bank_pkg`:**
  - `popcount` function.
  - `id_width(n)` function.
  - Default `N_TELLERS` constant, shared with the queue and display blocks.
- **Sub-module `teller_rr_arbiter`:**
  - Combinational round-robin first-set search.
  - Inputs: request mask and start pointer. Outputs: `grant_valid` and `grant_id`.
  - Instantiated once.

## Test plan
All scenarios use N_TELLERS=3.
- **Reset:** assert `rst` mid-cycle with `busy`=111 → immediately `busy`=000, all counts 0, `cust_ready`=0, `served_total`=0.
- **Opening windows:** `teller_on`=111, `cust_valid`=0 → next cycle `open_count`=3, `free_count`=3, `cust_ready`=1, `assign_id`=0.
- **Back-to-back accepts:** three accepts, `cust_valid` held → ids 0,1,2 in turn. `free_count` steps 3,2,1,0. `cust_ready`=0 afterwards, `served_total`=3.
- **Done and round-robin wrap:** with `busy`=111, pulse `done`=010, then `done`=001 on the following cycle → `assign_id`=1, then `rr_ptr` wrap behaviour shows. A `done` on an idle window leaves `busy` unchanged.
- **Closing a busy window:** `teller_on` 111→011 with window 2 busy → `busy[2]` stays 1, `open_count`=2, `busy_count` counts window 2. After `done[2]`, window 2 is never granted.
- **Saturation:** TOTAL_W=2 with 5 accepts → `served_total` stops at 3.
